sqrt_prenorm: RTL and testbench



---
 rtl/sqrt_pkg.sv | 13 +
 rtl/sqrt_prenorm.sv | 95 +++++++++
 tb/tb_sqrt_prenorm.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the square-root range reduction, core wrapper and post-stage.
package sqrt_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, OUT} sqrt_state_e;

  localparam int MANT_W    = 15;
  localparam int MANT_FRAC = 8;
  localparam int RANGE_LO  = 256;
  localparam int RANGE_HI  = 1023;

  localparam int IN_W_DEF    = 32;
  localparam int IN_FRAC_DEF = 16;
  localparam int EXP_W_DEF   = 5;
endpackage

// File: rtl/sqrt_prenorm.sv
// Normalises an unsigned fixed-point operand to m * 4^e with m in [1.0, 4.0),
// one 2-bit shift per cycle; m is emitted as ufix15_En8.
module sqrt_prenorm
  import sqrt_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int IN_FRAC = IN_FRAC_DEF,
  parameter int EXP_W   = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero
);

  sqrt_state_e       state_q, state_d;
  logic [IN_W-1:0]   w_q, w_d;
  logic [EXP_W-1:0]  e_q, e_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  oexp_q, oexp_d;
  logic              zero_q, zero_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      w_q     <= '0;
      e_q     <= '0;
      mant_q  <= '0;
      oexp_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      e_q     <= e_d;
      mant_q  <= mant_d;
      oexp_q  <= oexp_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    e_d     = e_q;
    mant_d  = mant_q;
    oexp_d  = oexp_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          w_d     = in_data;
          e_d     = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (w_q == '0) begin
          zero_d  = 1'b1;
          mant_d  = '0;
          oexp_d  = '0;
          state_d = OUT;
        end else if (|w_q[IN_W-1:IN_FRAC+2]) begin
          // Value >= 4.0: divide by 4, truncating the dropped bits.
          w_d = w_q >> 2;
          e_d = e_q + EXP_W'(1);
        end else if (w_q[IN_FRAC+1:IN_FRAC] == 2'b00) begin
          w_d = w_q << 2;
          e_d = e_q - EXP_W'(1);
        end else begin
          mant_d  = w_q[IN_FRAC+6:IN_FRAC-8];
          oexp_d  = e_q;
          zero_d  = 1'b0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_mant  = mant_q;
  assign out_exp   = oexp_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_sqrt_prenorm.sv
// Directed checks of sqrt_prenorm: normalisation results, latency, backpressure, reset abort.
module tb_sqrt_prenorm;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_mant;
  logic [4:0]  out_exp;
  logic        out_zero;

  int total = 0;
  int fails = 0;

  sqrt_prenorm dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand with out_ready high; latency counts the accept edge as 1.
  task automatic run(input logic [31:0] d, input logic [14:0] em, input logic [4:0] ee,
                     input logic ez, input int el, input string tag);
    int lat;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_mant"}, out_mant, em);
    chk({tag, "_exp"}, out_exp, ee);
    chk({tag, "_zero"}, out_zero, ez);
    if (!out_zero)
      chk({tag, "_range"}, (out_mant >= 15'd256 && out_mant <= 15'd1023), 1);
    tick();
    chk({tag, "_drop_valid"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mant", out_mant, 0);
    chk("rst_exp", out_exp, 0);
    chk("rst_zero", out_zero, 0);

    run(32'h0002_0000, 15'h200, 5'd0,  1'b0, 2,  "two");
    run(32'h0010_0000, 15'h100, 5'd2,  1'b0, 4,  "sixteen");
    run(32'h0000_4000, 15'h100, 5'h1F, 1'b0, 3,  "quarter");
    run(32'hFFFF_FFFF, 15'h3FF, 5'd7,  1'b0, 9,  "max");
    run(32'h0000_0001, 15'h100, 5'h18, 1'b0, 10, "min");
    run(32'h0000_0000, 15'h000, 5'd0,  1'b1, 2,  "zero");
    run(32'h0003_0000, 15'h300, 5'd0,  1'b0, 2,  "three");

    // Backpressure: hold result for 5 cycles while a second operand is offered.
    in_data   = 32'h0010_0000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp_lat", lat, 4);
    in_valid = 1'b1;
    in_data  = 32'h0002_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_mant", out_mant, 15'h100);
      chk("bp_exp", out_exp, 5'd2);
      chk("bp_zero", out_zero, 0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_no_accept", in_ready, 1);

    // Reset in the middle of a long left-shift scan.
    in_data  = 32'h0000_0001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_mant", out_mant, 0);
    chk("mid_rst_exp", out_exp, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) lat++;
    end
    chk("mid_rst_never_presented", lat, 0);
    run(32'h0002_0000, 15'h200, 5'd0, 1'b0, 2, "post_rst");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
